// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: fetch FSM states, PC increment and the issue payload.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_INCR = XLEN'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } issue_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack channel plus the decode-side valid/ready channel.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [XLEN-1:0]    pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC select: branch target (imm << 2) when taken, else PC + 4, modulo 2^64.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] bus_imm,
  input  logic            branch,
  input  logic            uncondbranch,
  input  logic            alu_zero,
  output logic [XLEN-1:0] next_pc_c
);

  logic            taken_c;
  logic [XLEN-1:0] offset_c;

  always_comb begin
    taken_c   = uncondbranch | (branch & alu_zero);
    offset_c  = bus_imm << 2;
    next_pc_c = pc + (taken_c ? offset_c : PC_INCR);
  end

endmodule

// File: rtl/fetch_unit.sv
// Three-state fetch unit: boot-load PC, fetch one word from imem, hold it for decode until accepted.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [XLEN-1:0]    startPC,
  input  logic [XLEN-1:0]    BusImm,
  input  logic               Branch,
  input  logic               Uncondbranch,
  input  logic               ALUZero,
  fetch_unit_if.master       bus,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_e      state_q, state_d;
  issue_pkt_t        issue_q, issue_d;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [XLEN-1:0]   next_pc_c;
  logic              accept_c;

  next_pc_calc u_next_pc (
    .pc           (issue_q.pc),
    .bus_imm      (BusImm),
    .branch       (Branch),
    .uncondbranch (Uncondbranch),
    .alu_zero     (ALUZero),
    .next_pc_c    (next_pc_c)
  );

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= BOOT;
      issue_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      issue_q       <= issue_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      retired_q     <= retired_d;
    end
  end

  // Handshake flags are derived from the next state so they line up with state_q.
  always_comb begin
    state_d   = state_q;
    issue_d   = issue_q;
    retired_d = retired_q;
    accept_c  = 1'b0;

    unique case (state_q)
      BOOT: begin
        issue_d.pc = startPC;
        state_d    = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          issue_d.instr = bus.imem_rdata;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        accept_c = bus.instr_ready;
        if (accept_c) begin
          issue_d.pc = next_pc_c;
          retired_d  = retired_q + CNT_W'(1);
          state_d    = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == ISSUE);
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = issue_q.pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = issue_q.instr;
  assign bus.pc          = issue_q.pc;
  assign retired         = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of branch/handshake cases plus reset and wrap sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned CW = 4;

  logic            CLK;
  logic            resetl;
  logic [63:0]     startPC;
  logic [63:0]     BusImm;
  logic            Branch;
  logic            Uncondbranch;
  logic            ALUZero;
  logic [CW-1:0]   retired;

  fetch_unit_if bus();

  fetch_unit #(.CNT_W(CW)) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .startPC      (startPC),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .bus          (bus.master),
    .retired      (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        br;
    logic        ub;
    logic        zero;
    logic [63:0] imm;
    int          ack_dly;
    int          rdy_dly;
    logic [63:0] exp_next;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t          vecs [10];
  exp_t          sb [$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_ret = '0;

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic noise();
    Branch       = 1'($urandom);
    Uncondbranch = 1'($urandom);
    ALUZero      = 1'($urandom);
    BusImm       = {$urandom, $urandom};
  endtask

  // One full fetch/issue/accept transaction starting from (or waiting for) FETCH.
  task automatic run_one(input logic br, input logic ub, input logic zero, input logic [63:0] imm,
                         input int ack_dly, input int rdy_dly, input logic [63:0] exp_addr,
                         input logic [31:0] word);
    int   n;
    int   req_cyc;
    exp_t e;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    check("fetch_req_seen", 64'(bus.imem_req), 64'd1);
    check("imem_addr", bus.imem_addr, exp_addr);
    check("valid_low_in_fetch", 64'(bus.instr_valid), 64'd0);
    req_cyc = 0;
    for (int i = 0; i < ack_dly; i++) begin
      req_cyc += int'(bus.imem_req);
      noise();
      step();
    end
    req_cyc += int'(bus.imem_req);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    sb.push_back('{pc: exp_addr, instr: word});
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    check("req_held_cycles", 64'(req_cyc), 64'(ack_dly + 1));
    check("issue_valid", 64'(bus.instr_valid), 64'd1);
    check("issue_req_low", 64'(bus.imem_req), 64'd0);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check("issue_instr", 64'(bus.instr), 64'(e.instr));
    check("issue_pc", bus.pc, e.pc);
    for (int i = 0; i < rdy_dly; i++) begin
      noise();
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = ~word;
      step();
      check("hold_instr", 64'(bus.instr), 64'(e.instr));
      check("hold_pc", bus.pc, e.pc);
      check("hold_valid", 64'(bus.instr_valid), 64'd1);
    end
    bus.imem_ack     = 1'b0;
    check("retired_before_accept", 64'(retired), 64'(exp_ret));
    Branch           = br;
    Uncondbranch     = ub;
    ALUZero          = zero;
    BusImm           = imm;
    bus.instr_ready  = 1'b1;
    step();
    bus.instr_ready  = 1'b0;
    noise();
    exp_ret++;
    check("retired", 64'(retired), 64'(exp_ret));
    check("valid_drops_after_accept", 64'(bus.instr_valid), 64'd0);
  endtask

  initial begin
    int          t0;
    logic [63:0] addr;

    //          br    ub    zero  imm                      ack rdy next
    vecs[0] = '{1'b0, 1'b0, 1'b0, 64'h0,                   0, 0, 64'h1004};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h7,                   0, 0, 64'h1008};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 64'h3FE,                 0, 0, 64'h2000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h1FF8};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 64'h402,                 1, 0, 64'h3000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 64'h5,                   0, 1, 64'h3014};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 64'h3000};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 64'h5,                   0, 0, 64'h3004};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 64'h64,                  0, 0, 64'h3008};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 64'h0,                   3, 4, 64'h300C};

    resetl          = 1'b0;
    startPC         = 64'h1000;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    noise();
    #3;
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_pc", bus.pc, 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    step();
    resetl = 1'b1;
    check("boot_req_low", 64'(bus.imem_req), 64'd0);
    step();

    t0   = cyc;
    addr = startPC;
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].br, vecs[i].ub, vecs[i].zero, vecs[i].imm,
              vecs[i].ack_dly, vecs[i].rdy_dly, addr, 32'hA000_0000 | 32'(i));
      if (i == 2) begin
        check("three_retired_in_six", 64'(cyc - t0), 64'd6);
        check("retired_three", 64'(retired), 64'd3);
      end
      addr = vecs[i].exp_next;
    end
    check("after_table_addr", bus.imem_addr, 64'h300C);

    // Asynchronous reset mid-FETCH, then a stray ack during BOOT.
    check("pre_reset_in_fetch", 64'(bus.imem_req), 64'd1);
    #2;
    resetl = 1'b0;
    #1;
    check("async_rst_req", 64'(bus.imem_req), 64'd0);
    check("async_rst_valid", 64'(bus.instr_valid), 64'd0);
    check("async_rst_instr", 64'(bus.instr), 64'd0);
    check("async_rst_addr", bus.imem_addr, 64'd0);
    check("async_rst_retired", 64'(retired), 64'd0);
    step();
    startPC        = 64'hFFFF_FFFF_FFFF_FFFC;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    resetl         = 1'b1;
    check("boot_no_req", 64'(bus.imem_req), 64'd0);
    step();
    check("stray_ack_ignored_valid", 64'(bus.instr_valid), 64'd0);
    check("refetch_req", 64'(bus.imem_req), 64'd1);
    check("refetch_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.imem_ack = 1'b0;
    exp_ret      = '0;

    run_one(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678);
    check("pc_wrap_to_zero", bus.imem_addr, 64'h0);

    for (int k = 0; k < 15; k++) begin
      run_one(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 64'(k) << 2, 32'hB000_0000 | 32'(k));
      if (k == 13) check("retired_all_ones", 64'(retired), 64'hF);
    end
    check("retired_wrap", 64'(retired), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
